// File: rtl/tagged_mem_pkg.sv
// ============================================================================
// Module      : tagged_mem_pkg
// Description : Shared bus command / access size encodings and defaults for
//               the tagged memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tagged_mem_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_t;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_t;

    localparam int DEF_MEM_64BIT_LINES = 2048;
    localparam int DEF_MEM_LATENCY     = 4;
    localparam int DEF_NUM_TAGS        = 15;
    localparam int TAG_W               = 4;

    // Stores never consume a tag, so they still answer when every tag is busy.
    localparam logic [TAG_W-1:0] STORE_ALL_BUSY_RESP = 4'd15;

    function automatic logic [2:0] size_align(mem_size_t size, logic [2:0] offset);
        case (size)
            BYTE:    return offset;
            HALF:    return {offset[2:1], 1'b0};
            WORD:    return {offset[2], 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] size_byte_mask(mem_size_t size, logic [2:0] offset);
        logic [7:0] base;
        case (size)
            BYTE:    base = 8'h01;
            HALF:    base = 8'h03;
            WORD:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << size_align(size, offset);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tagged_mem_if.sv
// ============================================================================
// Module      : tagged_mem_if
// Description : Processor <-> memory bus. proc2mem_size exists only when
//               MEM_SIZE_PORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tagged_mem_if;
    import tagged_mem_pkg::*;

    logic [31:0]  proc2mem_addr;
    logic [63:0]  proc2mem_data;
    bus_command_t proc2mem_command;
`ifdef MEM_SIZE_PORT_EN
    mem_size_t    proc2mem_size;
`endif
    logic [3:0]   mem2proc_response;
    logic [63:0]  mem2proc_data;
    logic [3:0]   mem2proc_tag;

`ifdef MEM_SIZE_PORT_EN
    modport master (
        output proc2mem_addr, proc2mem_data, proc2mem_command, proc2mem_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );
    modport slave (
        input  proc2mem_addr, proc2mem_data, proc2mem_command, proc2mem_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );
`else
    modport master (
        output proc2mem_addr, proc2mem_data, proc2mem_command,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );
    modport slave (
        input  proc2mem_addr, proc2mem_data, proc2mem_command,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );
`endif

endinterface

`default_nettype wire

// File: rtl/tagged_mem_mem_tag_alloc.sv
// ============================================================================
// Module      : mem_tag_alloc
// Description : Load tag busy vector with lowest-free-tag encoder; tags are
//               1..NUM_TAGS, 0 means none free.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_tag_alloc
    import tagged_mem_pkg::*;
#(
    parameter int NUM_TAGS = DEF_NUM_TAGS
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             alloc_en,
    input  wire logic             free_en,
    input  wire logic [TAG_W-1:0] free_tag,
    output logic      [TAG_W-1:0] lowest_free
);

    logic [NUM_TAGS-1:0] busy_q;
    logic [NUM_TAGS-1:0] busy_d;

    always_comb begin
        lowest_free = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) lowest_free = TAG_W'(i + 1);
        end
    end

    // The completing tag is still busy in its own cycle, so it never collides
    // with the tag being allocated.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (free_en && (free_tag == TAG_W'(i + 1)))     busy_d[i] = 1'b0;
            if (alloc_en && (lowest_free == TAG_W'(i + 1))) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

endmodule

`default_nettype wire

// File: rtl/tagged_mem.sv
// ============================================================================
// Module      : tagged_mem
// Description : Tagged fixed-latency memory model. Define MEM_SIZE_PORT_EN for
//               sub-line (byte/half/word) store masking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tagged_mem
    import tagged_mem_pkg::*;
#(
    parameter int MEM_LATENCY     = DEF_MEM_LATENCY,
    parameter int NUM_TAGS        = DEF_NUM_TAGS,
    parameter int MEM_64BIT_LINES = DEF_MEM_64BIT_LINES
) (
    input  wire logic  clock,
    input  wire logic  reset,
    tagged_mem_if.slave bus
);

    localparam int LINE_W = $clog2(MEM_64BIT_LINES);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] line;
    } inflight_t;

    logic [63:0] unified_memory [MEM_64BIT_LINES-1:0];

    inflight_t         pipe_q [MEM_LATENCY];
    inflight_t         pipe_d [MEM_LATENCY];
    inflight_t         done;
    logic [LINE_W-1:0] line_idx;
    logic              in_range;
    logic              load_accept;
    logic              store_accept;
    logic [TAG_W-1:0]  lowest_free;
    logic [TAG_W-1:0]  response;
    logic [7:0]        wr_mask;
    logic [63:0]       wr_data;

    assign line_idx = bus.proc2mem_addr[3 +: LINE_W];
    assign in_range = bus.proc2mem_addr < 32'(MEM_64BIT_LINES * 8);
    assign done     = pipe_q[MEM_LATENCY-1];

    mem_tag_alloc #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_alloc (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (load_accept),
        .free_en     (done.valid),
        .free_tag    (done.tag),
        .lowest_free (lowest_free)
    );

    always_comb begin
        response     = '0;
        load_accept  = 1'b0;
        store_accept = 1'b0;
        if (!reset && in_range) begin
            case (bus.proc2mem_command)
                BUS_LOAD: begin
                    if (lowest_free != '0) begin
                        response    = lowest_free;
                        load_accept = 1'b1;
                    end
                end
                BUS_STORE: begin
                    store_accept = 1'b1;
                    response     = (lowest_free != '0) ? lowest_free : STORE_ALL_BUSY_RESP;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem2proc_response = response;

`ifdef MEM_SIZE_PORT_EN
    assign wr_mask = size_byte_mask(bus.proc2mem_size, bus.proc2mem_addr[2:0]);
    assign wr_data = bus.proc2mem_data << {size_align(bus.proc2mem_size, bus.proc2mem_addr[2:0]), 3'b000};
`else
    assign wr_mask = 8'hFF;
    assign wr_data = bus.proc2mem_data;
`endif

    // Storage is deliberately outside reset so preloaded contents survive it.
    always_ff @(posedge clock) begin
        if (store_accept) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask[b]) unified_memory[line_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        pipe_d[0].valid = load_accept;
        pipe_d[0].tag   = lowest_free;
        pipe_d[0].line  = line_idx;
        for (int i = 1; i < MEM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < MEM_LATENCY; i++) begin
            if (reset) pipe_q[i] <= '0;
            else       pipe_q[i] <= pipe_d[i];
        end
    end

    // Data is read in the completion cycle itself, so a same-cycle store is
    // not yet visible while every earlier store is.
    always_comb begin
        bus.mem2proc_tag  = '0;
        bus.mem2proc_data = '0;
        if (!reset && done.valid) begin
            bus.mem2proc_tag  = done.tag;
            bus.mem2proc_data = unified_memory[done.line];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tagged_mem.sv
// ============================================================================
// Module      : tb_tagged_mem
// Description : Directed vector bench for tagged_mem, plus a deep-latency
//               instance used to exhaust the tag pool.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tagged_mem;
    import tagged_mem_pkg::*;

    localparam logic [63:0] P0 = 64'hA5A5_0000_0000_5A5A;
    localparam logic [63:0] P2 = 64'h1122_3344_5566_7788;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    tagged_mem_if bus ();
    tagged_mem_if bus_deep ();

    tagged_mem dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    tagged_mem #(
        .MEM_LATENCY (20)
    ) dut_deep (
        .clock (clock),
        .reset (reset),
        .bus   (bus_deep)
    );

    typedef struct {
        bus_command_t cmd;
        logic [31:0]  addr;
        logic [63:0]  wdata;
        logic [3:0]   resp;
        logic [3:0]   tag;
        logic [63:0]  rdata;
    } vec_t;

    vec_t vecs [19];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input bus_command_t cmd, input logic [31:0] addr, input logic [63:0] data);
        bus.proc2mem_command = cmd;
        bus.proc2mem_addr    = addr;
        bus.proc2mem_data    = data;
    endtask

    // One clock cycle on the main instance: drive, check mid-cycle, advance.
    task automatic run_cycle(input string name, input bus_command_t cmd, input logic [31:0] addr,
                             input logic [63:0] data, input logic [3:0] er, input logic [3:0] et,
                             input logic [63:0] ed);
        drive(cmd, addr, data);
        @(negedge clock);
        check({name, " resp"}, 64'(bus.mem2proc_response), 64'(er));
        check({name, " tag"},  64'(bus.mem2proc_tag),      64'(et));
        check({name, " data"}, bus.mem2proc_data,          ed);
        @(posedge clock);
        #1;
    endtask

    task automatic deep_cycle(input string name, input bus_command_t cmd, input logic [63:0] data,
                              input logic [3:0] er, input logic [3:0] et, input logic [63:0] ed);
        bus_deep.proc2mem_command = cmd;
        bus_deep.proc2mem_addr    = 32'h8;
        bus_deep.proc2mem_data    = data;
        @(negedge clock);
        check({name, " resp"}, 64'(bus_deep.mem2proc_response), 64'(er));
        check({name, " tag"},  64'(bus_deep.mem2proc_tag),      64'(et));
        check({name, " data"}, bus_deep.mem2proc_data,          ed);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(BUS_NONE, 32'h0, 64'h0);
        bus_deep.proc2mem_command = BUS_NONE;
        bus_deep.proc2mem_addr    = 32'h0;
        bus_deep.proc2mem_data    = 64'h0;
`ifdef MEM_SIZE_PORT_EN
        bus.proc2mem_size      = DOUBLE;
        bus_deep.proc2mem_size = DOUBLE;
`endif
        // Preload happens while reset is held and must survive it.
        dut.unified_memory[0] <= P0;
        dut.unified_memory[2] <= P2;
        @(posedge clock);
        #1;
        run_cycle("in_reset", BUS_LOAD, 32'h10, 64'h0, 4'd0, 4'd0, 64'h0);
        reset = 1'b0;

        vecs[0]  = '{BUS_LOAD,  32'h10,   64'h0,    4'd1, 4'd0, 64'h0};
        vecs[1]  = '{BUS_STORE, 32'h20,   64'hDEAD, 4'd2, 4'd0, 64'h0};
        vecs[2]  = '{BUS_LOAD,  32'h20,   64'h0,    4'd2, 4'd0, 64'h0};
        vecs[3]  = '{BUS_NONE,  32'h0,    64'h0,    4'd0, 4'd0, 64'h0};
        vecs[4]  = '{BUS_NONE,  32'h0,    64'h0,    4'd0, 4'd1, P2};
        vecs[5]  = '{BUS_LOAD,  32'h10,   64'h0,    4'd1, 4'd0, 64'h0};
        vecs[6]  = '{BUS_NONE,  32'h0,    64'h0,    4'd0, 4'd2, 64'hDEAD};
        vecs[7]  = '{BUS_LOAD,  32'h4000, 64'h0,    4'd0, 4'd0, 64'h0};
        vecs[8]  = '{BUS_STORE, 32'h4000, 64'hFFFF, 4'd0, 4'd0, 64'h0};
        vecs[9]  = '{BUS_STORE, 32'h10,   64'h0BAD, 4'd2, 4'd1, P2};
        vecs[10] = '{BUS_LOAD,  32'h10,   64'h0,    4'd1, 4'd0, 64'h0};
        vecs[11] = '{BUS_LOAD,  32'h0,    64'h0,    4'd2, 4'd0, 64'h0};
        vecs[12] = '{BUS_STORE, 32'h18,   64'h1234, 4'd3, 4'd0, 64'h0};
        vecs[13] = '{BUS_LOAD,  32'h18,   64'h0,    4'd3, 4'd0, 64'h0};
        vecs[14] = '{BUS_NONE,  32'h0,    64'h0,    4'd0, 4'd1, 64'h0BAD};
        vecs[15] = '{BUS_NONE,  32'h0,    64'h0,    4'd0, 4'd2, P0};
        vecs[16] = '{BUS_NONE,  32'h0,    64'h0,    4'd0, 4'd0, 64'h0};
        vecs[17] = '{BUS_NONE,  32'h0,    64'h0,    4'd0, 4'd3, 64'h1234};
        vecs[18] = '{BUS_NONE,  32'h0,    64'h0,    4'd0, 4'd0, 64'h0};

        for (int i = 0; i < 19; i++) begin
            run_cycle($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].wdata,
                      vecs[i].resp, vecs[i].tag, vecs[i].rdata);
        end

        // Reset with two loads in flight: nothing may complete afterwards.
        run_cycle("mid0", BUS_LOAD, 32'h10, 64'h0, 4'd1, 4'd0, 64'h0);
        run_cycle("mid1", BUS_LOAD, 32'h18, 64'h0, 4'd2, 4'd0, 64'h0);
        reset = 1'b1;
        run_cycle("mid_rst", BUS_LOAD, 32'h10, 64'h0, 4'd0, 4'd0, 64'h0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            run_cycle($sformatf("flush%0d", k), BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
        end
        run_cycle("post_ld", BUS_LOAD, 32'h10, 64'h0, 4'd1, 4'd0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            run_cycle($sformatf("post_wait%0d", k), BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
        end
        run_cycle("post_done", BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd1, 64'h0BAD);

`ifdef MEM_SIZE_PORT_EN
        bus.proc2mem_size = DOUBLE;
        run_cycle("sz_clr", BUS_STORE, 32'h30, 64'h0, 4'd1, 4'd0, 64'h0);
        bus.proc2mem_size = BYTE;
        run_cycle("sz_byte", BUS_STORE, 32'h33, 64'hAB, 4'd1, 4'd0, 64'h0);
        bus.proc2mem_size = DOUBLE;
        run_cycle("sz_ld", BUS_LOAD, 32'h33, 64'h0, 4'd1, 4'd0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            run_cycle($sformatf("sz_wait%0d", k), BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
        end
        run_cycle("sz_done", BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd1, 64'h00000000AB000000);
`endif

        // Tag exhaustion on the 20-cycle instance: tags 1..15, drop, store
        // answers 15, retry wins tag 1 only once tag 1 has completed.
        for (int c = 0; c < 22; c++) begin
            bus_command_t cmd;
            logic [3:0]   er;
            logic [3:0]   et;
            logic [63:0]  ed;
            cmd = (c == 16) ? BUS_STORE : BUS_LOAD;
            if (c < 15)       er = 4'(c + 1);
            else if (c == 16) er = 4'd15;
            else if (c == 21) er = 4'd1;
            else              er = 4'd0;
            et = (c >= 20) ? 4'(c - 19) : 4'd0;
            ed = (c >= 20) ? 64'h77 : 64'h0;
            deep_cycle($sformatf("deep%0d", c), cmd, 64'h77, er, et, ed);
        end
        bus_deep.proc2mem_command = BUS_NONE;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
